// File: rtl/pipe_alu_md_pkg.sv
// Shared op-code constants and control-state encoding
// for the ALU / multiply-divide pipeline unit.
package pipe_alu_md_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_RSV  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_NOR  = 4'h6;
   localparam logic [3:0] OP_SLTU = 4'h7;
   localparam logic [3:0] OP_SLT  = 4'h8;
   localparam logic [3:0] OP_SLL  = 4'h9;
   localparam logic [3:0] OP_SRL  = 4'hA;
   localparam logic [3:0] OP_SRA  = 4'hB;
   localparam logic [3:0] OP_GTZ  = 4'hC;
   localparam logic [3:0] OP_MULU = 4'hD;
   localparam logic [3:0] OP_DIVU = 4'hE;
   localparam logic [3:0] OP_DIV  = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } state_t;

endpackage

// File: rtl/pipe_alu_md_if.sv
// Request/response bundle between a requester
// and the ALU / multiply-divide unit.
interface pipe_alu_md_if #(
   parameter int WIDTH = 32
);
   logic             i_Valid;
   logic [3:0]       i_ALUOp;
   logic [WIDTH-1:0] i_In1;
   logic [WIDTH-1:0] i_In2;
   logic             i_Flush;
   logic             o_Ready;
   logic             o_Valid;
   logic [WIDTH-1:0] o_Result;
   logic [WIDTH-1:0] o_ResultHi;
   logic             o_Zero;

   modport master (
      output i_Valid, i_ALUOp, i_In1, i_In2, i_Flush,
      input  o_Ready, o_Valid, o_Result, o_ResultHi, o_Zero
   );

   modport slave (
      input  i_Valid, i_ALUOp, i_In1, i_In2, i_Flush,
      output o_Ready, o_Valid, o_Result, o_ResultHi, o_Zero
   );
endinterface

// File: rtl/pipe_alu_md_md_iter.sv
// Iterative datapath: shift-add multiply and restoring divide,
// one step per cycle; the final step is presented combinationally.
module md_iter
   import pipe_alu_md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic             busy, is_mul, neg_q, neg_r, dz;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc, lo_q, opb, a_q;
   logic [WIDTH-1:0] acc_n, lo_n;
   logic [WIDTH:0]   sum, shf, diff;
   logic             sa, sb;

   assign sa = (op == OP_DIV) & a[WIDTH-1];
   assign sb = (op == OP_DIV) & b[WIDTH-1];

   assign sum  = {1'b0, acc} + (lo_q[0] ? {1'b0, opb} : '0);
   assign shf  = {acc, lo_q[WIDTH-1]};
   assign diff = shf - {1'b0, opb};

   always_comb begin
      acc_n = sum[WIDTH:1];
      lo_n  = {sum[0], lo_q[WIDTH-1:1]};
      if (!is_mul) begin
         acc_n = diff[WIDTH] ? shf[WIDTH-1:0] : diff[WIDTH-1:0];
         lo_n  = {lo_q[WIDTH-2:0], ~diff[WIDTH]};
      end
   end

   // divide works on magnitudes; signs are restored here
   always_comb begin
      lo = lo_n;
      hi = acc_n;
      if (!is_mul) begin
         if (dz) begin
            lo = '1;
            hi = a_q;
         end else begin
            lo = neg_q ? -lo_n : lo_n;
            hi = neg_r ? -acc_n : acc_n;
         end
      end
   end

   assign done = busy && (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy   <= 1'b0;
         cnt    <= '0;
         is_mul <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dz     <= 1'b0;
         acc    <= '0;
         lo_q   <= '0;
         opb    <= '0;
         a_q    <= '0;
      end else if (flush) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         cnt    <= '0;
         is_mul <= (op == OP_MULU);
         neg_q  <= sa ^ sb;
         neg_r  <= sa;
         dz     <= (b == '0);
         acc    <= '0;
         lo_q   <= sa ? -a : a;
         opb    <= sb ? -b : b;
         a_q    <= a;
      end else if (busy) begin
         acc  <= acc_n;
         lo_q <= lo_n;
         if (done) begin
            busy <= 1'b0;
            cnt  <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/pipe_alu_md.sv
// ALU with single-cycle ops and an iterative
// multiply/divide path behind a valid/ready request port.
module pipe_alu_md
   import pipe_alu_md_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic        i_clk,
   input  logic        i_rst,
   pipe_alu_md_if.slave bus
);
   state_t           state;
   logic             valid_q, ready, accept, multi, md_done;
   logic [WIDTH-1:0] a, b, alu, md_lo, md_hi, res_q, hi_q;
   logic [SHW-1:0]   sh;

   assign a      = bus.i_In1;
   assign b      = bus.i_In2;
   assign sh     = a[SHW-1:0];
   assign ready  = (state != ST_BUSY);
   assign multi  = (bus.i_ALUOp >= OP_MULU);
   assign accept = bus.i_Valid & ready & ~bus.i_Flush;

   assign bus.o_Ready    = ready;
   assign bus.o_Valid    = valid_q;
   assign bus.o_Result   = res_q;
   assign bus.o_ResultHi = hi_q;
   assign bus.o_Zero     = (res_q == '0);

   md_iter #(
      .WIDTH(WIDTH)
   ) u_md (
      .clk  (i_clk),
      .rst  (i_rst),
      .flush(bus.i_Flush),
      .start(accept & multi),
      .op   (bus.i_ALUOp),
      .a    (a),
      .b    (b),
      .done (md_done),
      .lo   (md_lo),
      .hi   (md_hi)
   );

   always_comb begin
      alu = '0;
      unique case (bus.i_ALUOp)
         OP_ADD:  alu = a + b;
         OP_SUB:  alu = a - b;
         OP_AND:  alu = a & b;
         OP_OR:   alu = a | b;
         OP_XOR:  alu = a ^ b;
         OP_NOR:  alu = ~(a | b);
         OP_SLTU: alu[0] = (a < b);
         OP_SLT:  alu[0] = ($signed(a) < $signed(b));
         OP_SLL:  alu = b << sh;
         OP_SRL:  alu = b >> sh;
         OP_SRA:  alu = $signed(b) >>> sh;
         OP_GTZ:  alu[0] = ($signed(a) > 0);
         default: alu = '0;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= ST_IDLE;
         valid_q <= 1'b0;
         res_q   <= '0;
         hi_q    <= '0;
      end else if (bus.i_Flush) begin
         state   <= ST_IDLE;
         valid_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         unique case (state)
            ST_BUSY: begin
               if (md_done) begin
                  state   <= ST_DONE;
                  valid_q <= 1'b1;
                  res_q   <= md_lo;
                  hi_q    <= md_hi;
               end
            end
            default: begin
               if (!accept) begin
                  state <= ST_IDLE;
               end else if (multi) begin
                  state <= ST_BUSY;
               end else begin
                  state   <= ST_DONE;
                  valid_q <= 1'b1;
                  res_q   <= alu;
                  hi_q    <= '0;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_pipe_alu_md.sv
// Bench for pipe_alu_md: reference model with per-cycle compare,
// directed corner cases, and a small WIDTH=8 build.
module tb_pipe_alu_md;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      int          due;
      logic [31:0] lo;
      logic [31:0] hi;
   } exp_t;
   exp_t q[$];

   pipe_alu_md_if #(.WIDTH(32)) bus ();
   pipe_alu_md_if #(.WIDTH(8))  bus8 ();

   pipe_alu_md #(.WIDTH(32)) dut (
      .i_clk(clk), .i_rst(rst), .bus(bus)
   );
   pipe_alu_md #(.WIDTH(8)) dut8 (
      .i_clk(clk), .i_rst(rst), .bus(bus8)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %h required %h", name, act, req);
      end
   endtask

   // expected {hi, lo} straight from the operation definitions
   function automatic logic [63:0] model(input logic [3:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      logic [31:0] lo, hi;
      logic [4:0]  sh;
      sh = a[4:0];
      lo = 0;
      hi = 0;
      case (op)
         4'h0: lo = a + b;
         4'h1: lo = a - b;
         4'h3: lo = a & b;
         4'h4: lo = a | b;
         4'h5: lo = a ^ b;
         4'h6: lo = ~(a | b);
         4'h7: lo = {31'b0, a < b};
         4'h8: lo = {31'b0, $signed(a) < $signed(b)};
         4'h9: lo = b << sh;
         4'hA: lo = b >> sh;
         4'hB: lo = $signed(b) >>> sh;
         4'hC: lo = {31'b0, $signed(a) > 0};
         4'hD: {hi, lo} = {32'b0, a} * {32'b0, b};
         4'hE: begin
            if (b == 0) begin lo = '1; hi = a; end
            else begin lo = a / b; hi = a % b; end
         end
         4'hF: begin
            if (b == 0) begin lo = '1; hi = a; end
            else if (a == 32'h8000_0000 && b == '1) begin
               lo = a; hi = 0;
            end else begin
               lo = $signed(a) / $signed(b);
               hi = $signed(a) % $signed(b);
            end
         end
         default: lo = 0;
      endcase
      return {hi, lo};
   endfunction

   always @(negedge clk) begin
      if (q.size() > 0 && q[0].due == cyc) begin
         chk("m_valid", bus.o_Valid, 1);
         chk("m_lo", bus.o_Result, q[0].lo);
         chk("m_hi", bus.o_ResultHi, q[0].hi);
         chk("m_zero", bus.o_Zero, q[0].lo == 0);
         void'(q.pop_front());
      end else if (bus.o_Valid) begin
         chk("m_spurious_valid", bus.o_Valid, 0);
      end
   end

   // entered just after a negedge; returns just after a negedge
   task automatic issue(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit track);
      int   t;
      exp_t e;
      t = 0;
      while (!bus.o_Ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) chk("ready_timeout", bus.o_Ready, 1);
      bus.i_Valid = 1'b1;
      bus.i_ALUOp = op;
      bus.i_In1   = a;
      bus.i_In2   = b;
      if (track) begin
         e.due = cyc + 1 + ((op >= 4'hD) ? 32 : 0);
         {e.hi, e.lo} = model(op, a, b);
         q.push_back(e);
      end
   endtask

   task automatic run_lit(input string name, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lo, input logic [31:0] hi,
                          input int lat, input int busy_req);
      int n, busy;
      n = 0;
      busy = 0;
      issue(op, a, b, 1);
      do begin
         @(negedge clk);
         if (n == 0) bus.i_Valid = 1'b0;
         n++;
         if (!bus.o_Ready) busy++;
      end while (!bus.o_Valid && n < 100);
      chk({name, "_lat"}, 64'(n), 64'(lat));
      chk({name, "_busy"}, 64'(busy), 64'(busy_req));
      chk({name, "_lo"}, bus.o_Result, lo);
      chk({name, "_hi"}, bus.o_ResultHi, hi);
      chk({name, "_zero"}, bus.o_Zero, lo == 0);
   endtask

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int n8;
      bus.i_Valid = 0; bus.i_ALUOp = 0; bus.i_In1 = 0;
      bus.i_In2 = 0; bus.i_Flush = 0;
      bus8.i_Valid = 0; bus8.i_ALUOp = 0; bus8.i_In1 = 0;
      bus8.i_In2 = 0; bus8.i_Flush = 0;
      #1 rst = 1'b1;
      #2;
      chk("rst_valid", bus.o_Valid, 0);
      chk("rst_lo", bus.o_Result, 0);
      chk("rst_hi", bus.o_ResultHi, 0);
      chk("rst_ready", bus.o_Ready, 1);
      chk("rst_zero", bus.o_Zero, 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_lit("sub", 4'h1, 5, 7, 32'hFFFF_FFFE, 0, 1, 0);
      run_lit("mulu", 4'hD, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 1, 33, 32);
      run_lit("div", 4'hF, -32'sd7, 2, -32'sd3, -32'sd1, 33, 32);
      run_lit("divz", 4'hE, 9, 0, 32'hFFFF_FFFF, 9, 33, 32);
      run_lit("divov", 4'hF, 32'h8000_0000, 32'hFFFF_FFFF,
              32'h8000_0000, 0, 33, 32);
      run_lit("rsv", 4'h2, 3, 4, 0, 0, 1, 0);
      run_lit("sra", 4'hB, 4, 32'h8000_0000, 32'hF800_0000, 0, 1, 0);

      // flush during a divide, with a simultaneous request
      issue(4'hE, 100, 7, 0);
      @(negedge clk);
      bus.i_Valid = 1'b0;
      repeat (9) @(negedge clk);
      bus.i_Valid = 1'b1;
      bus.i_ALUOp = 4'h0;
      bus.i_Flush = 1'b1;
      @(negedge clk);
      bus.i_Flush = 1'b0;
      bus.i_Valid = 1'b0;
      chk("flush_ready", bus.o_Ready, 1);
      chk("flush_valid", bus.o_Valid, 0);
      repeat (40) @(negedge clk);
      run_lit("after_flush", 4'h0, 1, 1, 2, 0, 1, 0);

      // reset in the middle of a multiply
      issue(4'hD, 123, 456, 1);
      @(negedge clk);
      bus.i_Valid = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      q.delete();
      #1;
      chk("mrst_valid", bus.o_Valid, 0);
      chk("mrst_lo", bus.o_Result, 0);
      chk("mrst_hi", bus.o_ResultHi, 0);
      chk("mrst_ready", bus.o_Ready, 1);
      chk("mrst_zero", bus.o_Zero, 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      run_lit("first_req", 4'h4, 32'hF0, 32'h0F, 32'hFF, 0, 1, 0);
      repeat (40) @(negedge clk);

      // narrow build
      bus8.i_Valid = 1'b1;
      bus8.i_ALUOp = 4'hB;
      bus8.i_In1   = 8'd3;
      bus8.i_In2   = 8'h80;
      @(negedge clk);
      bus8.i_Valid = 1'b0;
      chk("w8_sra_valid", bus8.o_Valid, 1);
      chk("w8_sra_lo", bus8.o_Result, 8'hF0);
      bus8.i_Valid = 1'b1;
      bus8.i_ALUOp = 4'hD;
      bus8.i_In1   = 8'hFF;
      bus8.i_In2   = 8'hFF;
      n8 = 0;
      do begin
         @(negedge clk);
         bus8.i_Valid = 1'b0;
         n8++;
      end while (!bus8.o_Valid && n8 < 50);
      chk("w8_mul_lat", 64'(n8), 9);
      chk("w8_mul_lo", bus8.o_Result, 8'h01);
      chk("w8_mul_hi", bus8.o_ResultHi, 8'hFE);

      for (int i = 0; i < 300; i++) begin
         issue(4'($urandom_range(0, 15)), rnd_opnd(), rnd_opnd(), 1);
         @(negedge clk);
         bus.i_Valid = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      repeat (40) @(negedge clk);
      chk("drain", 64'(q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
